riscv_mc_controller: RTL and testbench
======================================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 Parameter MEM_LAT, default 0: extra memory wait cycles inserted in FETCH and MEMREAD; legal range 0..7.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-012 FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; one transition per clock edge, except as stated in REQ-016 and REQ-025.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR for op 0000011 or 0100011; EXECUTER for 0110011; EXECUTEI for 0010011; JAL for 1101111; BEQ for 1100011.
- MEMADR->MEMREAD for a load, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI->ALUWB.
- JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-014 Decoding any other op in DECODE SHALL pulse illegal for that cycle and go to FETCH.
REQ-015 Outputs SHALL be Moore per state (ALUSrcA/ALUSrcB/ALUOp/ResultSrc); all unlisted outputs are 0:
- FETCH: AdrSrc=0, IRWrite=1, 00/10/00, ResultSrc=10, PCUpdate=1.
- DECODE: 01/01/00.
- MEMADR: 10/01/00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: 10/00/10.
- EXECUTEI: 10/01/10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: 10/00/01, ResultSrc=00, Branch=1.
- JAL: 01/10/00, ResultSrc=00, PCUpdate=1.
REQ-016 Wait counter: FETCH and MEMREAD SHALL each last MEM_LAT+1 cycles. IRWrite and PCUpdate SHALL assert only in the final FETCH cycle. AdrSrc SHALL hold for all FETCH or MEMREAD cycles.
REQ-017 PCWrite SHALL equal PCUpdate | (Branch & Zero), combinationally from the current state and Zero.
REQ-018 ImmSrc SHALL be combinational from op: 00 for I-type/load, 01 for store, 10 for branch, 11 for jal, 00 otherwise.
REQ-019 ALU decoder:
- ALUOp 00 -> add.
- ALUOp 01 -> sub.
- ALUOp 10 by funct3: 000 -> sub if (op[5] & funct7b5), else add; 010 -> slt; 110 -> or; 111 -> and; other -> 000.

Reset
REQ-020 Reset SHALL force state FETCH and clear the wait counter to 0 immediately, without waiting for a clock edge.
REQ-021 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be 0.
REQ-022 All other outputs SHALL be 0 while reset is high.
REQ-023 The first FETCH SHALL begin on the first rising edge after reset deasserts.
REQ-024 Reset asserted mid-instruction SHALL abort the instruction with no further write enable asserted.

Configuration
REQ-025 With CTRL_HALT_EN defined, the block SHALL add a 1-bit input halt.
- halt=1 during FETCH SHALL hold the FSM in FETCH.
- While halted, IRWrite and PCWrite SHALL be 0 and the wait counter SHALL be held at 0.
- When halt falls, the full FETCH wait sequence SHALL restart.
- halt in any other state SHALL be ignored until the next FETCH.
REQ-026 Without CTRL_HALT_EN, the halt port and all halt logic SHALL be absent.

Structure
REQ-027 Shared package riscv_pkg SHALL hold the state enum, the opcode constants, the ALUOp encodings and the ALUControl encodings.
REQ-028 One sub-module, riscv_alu_decoder, SHALL implement REQ-019 combinationally; the FSM, wait counter and ImmSrc logic SHALL stay in riscv_mc_controller.

Verification
REQ-029 Reset: assert reset mid-MEMWRITE -> MemWrite=0 immediately; after release the FSM is in FETCH with IRWrite=1 and PCWrite=1.
REQ-030 lw, MEM_LAT=0: op=0000011 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); RegWrite=1 only in cycle 5, with ResultSrc=01.
REQ-031 sub R-type: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; instruction takes 4 cycles.
REQ-032 beq: Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; each case takes 3 cycles.
REQ-033 MEM_LAT=2, sw: FETCH lasts 3 cycles with IRWrite only in the third; MEMWRITE asserts MemWrite for 1 cycle; unknown op=0000000 -> illegal pulses for 1 cycle, then FETCH.
REQ-034 CTRL_HALT_EN: halt=1 for 10 cycles -> IRWrite stays 0; halt falls -> IRWrite=1 exactly MEM_LAT+1 cycles later.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state, opcode and ALU encodings for the multicycle RISC-V controller
// Contents: state_t FSM enum, opcode constants, ALUOp encodings, ALUControl encodings.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/riscv_mc_controller_if.sv
// rtl/riscv_mc_controller_if.sv - instruction-field inputs and datapath controls of the controller
// master: controller side (reads op/funct3/funct7b5/Zero, drives the datapath controls).
// slave:  datapath side (drives the instruction fields and Zero, reads the controls).
interface riscv_mc_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

endinterface

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - combinational ALUOp/funct decode into the ALU operation select
// Ports: alu_op (2), funct3 (3), op_b5 (opcode bit 5), funct7b5 (instr bit 30) in;
//        alu_control (3) out.
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op bit 5 set) can be a subtract; addi ignores bit 30.
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multicycle RISC-V control FSM with memory wait counter
// Parameter: MEM_LAT (0..7) extra wait cycles in FETCH and MEMREAD.
// Ports: clk, reset (async, active high); bus (riscv_mc_controller_if.master);
//        halt (only when CTRL_HALT_EN is defined) holds the FSM in FETCH.
// Optional feature macro: CTRL_HALT_EN.
module riscv_mc_controller
    import riscv_pkg::*;
#(
    parameter int MEM_LAT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef CTRL_HALT_EN
    input  logic                         halt,
`endif
    riscv_mc_controller_if.master        bus
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    // run_q is 0 from reset until the first clock edge after release, so the
    // first FETCH cycle is the one that starts on that edge.
    logic       run_q, run_d;

    logic       wait_last;
    logic       fetch_go;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       illegal_c;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       out_en;

    assign wait_last = (wait_q == LAT);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        run_d      = 1'b1;
        fetch_go   = 1'b1;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal_c  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
`ifdef CTRL_HALT_EN
        fetch_go   = ~halt;
`endif
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (!fetch_go) begin
                        // Halted: restart the wait sequence from zero when released.
                        wait_d = '0;
                    end else if (wait_last) begin
                        ir_write  = 1'b1;
                        pc_update = 1'b1;
                        wait_d    = '0;
                        state_d   = S_DECODE;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (bus.op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXECUTER;
                        OP_ITYPE:          state_d = S_EXECUTEI;
                        OP_JAL:            state_d = S_JAL;
                        OP_BEQ:            state_d = S_BEQ;
                        default: begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                    if (wait_last) begin
                        wait_d  = '0;
                        state_d = S_MEMWB;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_EXECUTER: begin
                    alu_src_a = 2'b10;
                    alu_op    = ALUOP_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = ALUOP_FUNCT;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    alu_op    = ALUOP_SUB;
                    branch    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_update = 1'b1;
                    state_d   = S_ALUWB;
                end
                default: begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    riscv_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op_b5       (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    // Every output is forced low while reset is high, including the op-derived ones.
    assign out_en = run_q & ~reset;

    assign bus.PCWrite    = out_en & (pc_update | (branch & bus.Zero));
    assign bus.AdrSrc     = out_en & adr_src;
    assign bus.MemWrite   = out_en & mem_write;
    assign bus.IRWrite    = out_en & ir_write;
    assign bus.RegWrite   = out_en & reg_write;
    assign bus.illegal    = out_en & illegal_c;
    assign bus.ResultSrc  = out_en ? result_src  : 2'b00;
    assign bus.ALUSrcA    = out_en ? alu_src_a   : 2'b00;
    assign bus.ALUSrcB    = out_en ? alu_src_b   : 2'b00;
    assign bus.ImmSrc     = out_en ? imm_src     : 2'b00;
    assign bus.ALUControl = out_en ? alu_control : 3'b000;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - scoreboard bench for riscv_mc_controller at MEM_LAT 0 and 2
module tb_riscv_mc_controller;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    logic probe = 1'b0;
`ifdef CTRL_HALT_EN
    logic halt0 = 1'b0;
    logic halt2 = 1'b0;
`endif

    riscv_mc_controller_if if0 ();
    riscv_mc_controller_if if2 ();

    riscv_mc_controller #(.MEM_LAT(0)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
`ifdef CTRL_HALT_EN
        .halt  (halt0),
`endif
        .bus   (if0)
    );

    riscv_mc_controller #(.MEM_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (rst2),
`ifdef CTRL_HALT_EN
        .halt  (halt2),
`endif
        .bus   (if2)
    );

    exp_t q0[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    logic [16:0] act0, act2;
    assign act0 = {if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.RegWrite,
                   if0.ResultSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ImmSrc, if0.ALUControl, if0.illegal};
    assign act2 = {if2.PCWrite, if2.AdrSrc, if2.MemWrite, if2.IRWrite, if2.RegWrite,
                   if2.ResultSrc, if2.ALUSrcA, if2.ALUSrcB, if2.ImmSrc, if2.ALUControl, if2.illegal};

    // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal
    function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [2:0] aluc,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, aluc, ill};
    endfunction

    // Monitor: compares every queued expectation against the sampled DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge probe);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if (act0 !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut0 got %b want %b", e.name, act0, e.exp);
                end
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                checks++;
                if (act2 !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut2 got %b want %b", e.name, act2, e.exp);
                end
            end
        end
    end

    task automatic step0(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input bit chk, input string nm, input logic [16:0] e);
        exp_t t;
        @(posedge clk);
        #1;
        if0.op = op; if0.funct3 = f3; if0.funct7b5 = f7; if0.Zero = z;
        if (chk) begin
            t.name = nm; t.exp = e;
            q0.push_back(t);
        end
    endtask

    task automatic step2(input logic [6:0] op, input bit chk, input string nm, input logic [16:0] e);
        exp_t t;
        @(posedge clk);
        #1;
        if2.op = op; if2.funct3 = 3'b000; if2.funct7b5 = 1'b0; if2.Zero = 1'b0;
        if (chk) begin
            t.name = nm; t.exp = e;
            q2.push_back(t);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete got timeout want finish");
        $fatal(1);
    end

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    // ALU table: op, funct3, funct7b5, expected ALUControl, expected ALUSrcB in execute
    logic [6:0] t_op   [8] = '{RT, RT, RT, RT, RT, RT, IT, IT};
    logic [2:0] t_f3   [8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b100, 3'b000, 3'b010};
    logic       t_f7   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] t_aluc [8] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b000, 3'b000, 3'b101};
    logic [1:0] t_b    [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};

    initial begin
        exp_t t;
        if0.op = 7'd0; if0.funct3 = 3'd0; if0.funct7b5 = 1'b0; if0.Zero = 1'b0;
        if2.op = 7'd0; if2.funct3 = 3'd0; if2.funct7b5 = 1'b0; if2.Zero = 1'b0;

        // ---------------- MEM_LAT = 0 ----------------
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "rst_outputs_sw", 17'd0);
        step0(BQ, 3'b000, 1'b0, 1'b1, 1, "rst_outputs_beq", 17'd0);
        step0(LW, 3'b010, 1'b0, 1'b0, 0, "", 17'd0);
        rst0 = 1'b0;

        step0(LW, 3'b010, 1'b0, 1'b0, 1, "lw_fetch",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step0(LW, 3'b010, 1'b0, 1'b0, 1, "lw_decode",  mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step0(LW, 3'b010, 1'b0, 1'b0, 1, "lw_memadr",  mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        step0(LW, 3'b010, 1'b0, 1'b0, 1, "lw_memread", mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        step0(LW, 3'b010, 1'b0, 1'b0, 1, "lw_memwb",   mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

        for (int i = 0; i < 8; i++) begin
            step0(t_op[i], t_f3[i], t_f7[i], 1'b0, 1, $sformatf("alu%0d_fetch", i),
                  mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
            step0(t_op[i], t_f3[i], t_f7[i], 1'b0, 1, $sformatf("alu%0d_decode", i),
                  mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
            step0(t_op[i], t_f3[i], t_f7[i], 1'b0, 1, $sformatf("alu%0d_execute", i),
                  mk(0,0,0,0,0,2'b00,2'b10,t_b[i],2'b00,t_aluc[i],0));
            step0(t_op[i], t_f3[i], t_f7[i], 1'b0, 1, $sformatf("alu%0d_aluwb", i),
                  mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        end

        for (int z = 1; z >= 0; z--) begin
            step0(BQ, 3'b000, 1'b0, 1'(z), 1, $sformatf("beq_z%0d_fetch", z),
                  mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
            step0(BQ, 3'b000, 1'b0, 1'(z), 1, $sformatf("beq_z%0d_decode", z),
                  mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
            step0(BQ, 3'b000, 1'b0, 1'(z), 1, $sformatf("beq_z%0d_beq", z),
                  mk(1'(z),0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        end

        step0(JL, 3'b000, 1'b0, 1'b0, 1, "jal_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
        step0(JL, 3'b000, 1'b0, 1'b0, 1, "jal_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
        step0(JL, 3'b000, 1'b0, 1'b0, 1, "jal_jal",    mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        step0(JL, 3'b000, 1'b0, 1'b0, 1, "jal_aluwb",  mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));

        step0(SW, 3'b010, 1'b0, 1'b0, 1, "sw_fetch",    mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "sw_decode",   mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "sw_memadr",   mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "sw_memwrite", mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        // Reset lands in the middle of the MEMWRITE cycle; outputs must drop at once.
        @(negedge clk);
        #1;
        rst0 = 1'b1;
        t.name = "rst_mid_memwrite"; t.exp = 17'd0;
        q0.push_back(t);
        #1;
        probe = 1'b1;
        #1;
        probe = 1'b0;
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "rst_hold", 17'd0);
        step0(SW, 3'b010, 1'b0, 1'b0, 0, "", 17'd0);
        rst0 = 1'b0;
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "post_rst_fetch",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step0(SW, 3'b010, 1'b0, 1'b0, 1, "post_rst_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));

        // ---------------- MEM_LAT = 2 ----------------
        step2(SW, 0, "", 17'd0);
        rst2 = 1'b0;
        step2(SW, 1, "sw2_fetch0",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step2(SW, 1, "sw2_fetch1",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step2(SW, 1, "sw2_fetch2",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step2(SW, 1, "sw2_decode",   mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        step2(SW, 1, "sw2_memadr",   mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        step2(SW, 1, "sw2_memwrite", mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));

        step2(BAD, 1, "bad_fetch0",  mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(BAD, 1, "bad_fetch1",  mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(BAD, 1, "bad_fetch2",  mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(BAD, 1, "bad_decode",  mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));

        step2(LW, 1, "lw2_fetch0",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "lw2_fetch1",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "lw2_fetch2",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "lw2_decode",   mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step2(LW, 1, "lw2_memadr",   mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        for (int i = 0; i < 3; i++)
            step2(LW, 1, $sformatf("lw2_memread%0d", i), mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        step2(LW, 1, "lw2_memwb",    mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

`ifdef CTRL_HALT_EN
        for (int i = 0; i < 10; i++) begin
            step2(LW, 1, $sformatf("halt_fetch%0d", i), mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
            halt2 = 1'b1;
        end
        step2(LW, 1, "unhalt_fetch0", mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        halt2 = 1'b0;
        step2(LW, 1, "unhalt_fetch1", mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "unhalt_fetch2", mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "unhalt_decode", mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
`else
        step2(LW, 1, "next_fetch0",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "next_fetch1",   mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step2(LW, 1, "next_fetch2",   mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
`endif

        repeat (2) @(posedge clk);
        checks++;
        if (q0.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain pending expectations got %0d want 0", q0.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
